// File: rtl/dispatch_queue_pkg.sv
// Shared definitions for the tensor-core dispatch stage: FU identifiers,
// default geometry and the decoded-instruction record.
package dispatch_queue_pkg;

    localparam int NUM_FU   = 5;
    localparam int DEPTH    = 4;
    localparam int WORD_W   = 32;
    localparam int FU_IDX_W = 3;

    // Scalar and matrix units share one index space, so LD_ST is split by domain.
    typedef enum logic [FU_IDX_W-1:0] {
        SC_ALU    = 3'd0,
        SC_LDST   = 3'd1,
        SC_BRANCH = 3'd2,
        MX_LDST   = 3'd3,
        MX_GEMM   = 3'd4
    } fu_id_t;

    typedef struct packed {
        logic [FU_IDX_W-1:0] fu_index;
        logic [WORD_W-1:0]   instr;
    } dispatch_t;

endpackage

// File: rtl/dispatch_queue_fu_fifo.sv
// Single-channel synchronous FIFO feeding one function unit; head entry is
// presented combinationally, and a flush clears pointers and count at the next edge.
module fu_fifo #(
    parameter int DEPTH  = 4,
    parameter int WORD_W = 32,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    // Guarding here keeps the counter bounded even if a caller misbehaves.
    assign w_push = push & ~full & ~flush;
    assign w_pop  = pop & ~empty & ~flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dispatch_queue.sv
// Dispatch stage: steers one decoded instruction per cycle into a per-FU FIFO,
// drains each FIFO independently over valid/ready, and flags out-of-range FU indices.
module dispatch_queue
    import dispatch_queue_pkg::*;
#(
    parameter int NUM_FU   = dispatch_queue_pkg::NUM_FU,
    parameter int DEPTH    = dispatch_queue_pkg::DEPTH,
    parameter int WORD_W   = dispatch_queue_pkg::WORD_W,
    parameter int FU_IDX_W = dispatch_queue_pkg::FU_IDX_W,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [FU_IDX_W-1:0]       in_fu_index,
    input  logic [WORD_W-1:0]         in_instr,
    input  logic                      flush,
    output logic [NUM_FU-1:0]         out_valid,
    input  logic [NUM_FU-1:0]         out_ready,
    output logic [NUM_FU*WORD_W-1:0]  out_instr,
    output logic [NUM_FU*CNT_W-1:0]   occupancy,
    output logic                      busy,
    output logic                      illegal_fu
);

    localparam logic [FU_IDX_W:0] LP_NUM_FU = (FU_IDX_W + 1)'(NUM_FU);

    logic [NUM_FU-1:0] w_sel;
    logic [NUM_FU-1:0] w_full;
    logic [NUM_FU-1:0] w_empty;
    logic              w_legal;
    logic              w_sel_full;
    logic              w_accept;
    logic              r_illegal;

    assign w_legal    = ({1'b0, in_fu_index} < LP_NUM_FU);
    assign w_sel_full = |(w_sel & w_full);
    // No full-bypass: a full FIFO blocks its index even while it pops this cycle.
    assign in_ready   = ~flush & (~w_legal | ~w_sel_full);
    assign w_accept   = in_valid & in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FU; gi++) begin : g_fu
            assign w_sel[gi]     = (in_fu_index == FU_IDX_W'(gi));
            assign out_valid[gi] = ~w_empty[gi];

            fu_fifo #(
                .DEPTH  (DEPTH),
                .WORD_W (WORD_W),
                .CNT_W  (CNT_W)
            ) u_fifo (
                .clk   (CLK),
                .rst_n (nRST),
                .push  (w_accept & w_sel[gi]),
                .pop   (out_ready[gi]),
                .flush (flush),
                .din   (in_instr),
                .dout  (out_instr[gi*WORD_W +: WORD_W]),
                .full  (w_full[gi]),
                .empty (w_empty[gi]),
                .count (occupancy[gi*CNT_W +: CNT_W])
            );
        end
    endgenerate

    assign busy = |out_valid;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_accept & ~w_legal;
        end
    end

    assign illegal_fu = r_illegal;

endmodule
